// File: rtl/m68k_bus_target_pkg.sv
// Shared definitions for the 68000 bus responder: default widths, the FSM
// state encoding and the bus-cycle start qualifier.
package m68k_bus_target_pkg;

    localparam int unsigned DEF_ADDR_BITS      = 23;
    localparam int unsigned DEF_TIMEOUT_BITS   = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 200;
    localparam int unsigned DATA_BITS          = 16;
    localparam int unsigned BE_BITS            = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_BERR = 2'd3
    } state_t;

    // A cycle starts once AS and at least one data strobe are low; writes
    // assert DS after AS, so AS alone must not start a cycle.
    function automatic logic bus_start(input logic as_n, input logic uds_n,
                                       input logic lds_n);
        return !as_n && (!uds_n || !lds_n);
    endfunction

endpackage

// File: rtl/m68k_bus_target_if.sv
// CPU bus + memory request bundle for m68k_bus_target.
//  slave  : the responder's view (samples CPU strobes, drives dtack/berr,
//           drives the memory request, samples mem_ack/mem_rdata).
//  master : the environment's view (CPU and memory model).
interface m68k_bus_target_if
    import m68k_bus_target_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
);
    logic                 as_n;
    logic                 uds_n;
    logic                 lds_n;
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] cpu_dout;
    logic [DATA_BITS-1:0] cpu_din;
    logic                 dtack_n;
    logic                 berr_n;
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [BE_BITS-1:0]   mem_be;
    logic [DATA_BITS-1:0] mem_wdata;
    logic                 mem_ack;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 busy;

    modport slave (
        input  as_n, uds_n, lds_n, rw, addr, cpu_dout, mem_ack, mem_rdata,
        output cpu_din, dtack_n, berr_n, mem_req, mem_we, mem_addr, mem_be,
               mem_wdata, busy
    );

    modport master (
        output as_n, uds_n, lds_n, rw, addr, cpu_dout, mem_ack, mem_rdata,
        input  cpu_din, dtack_n, berr_n, mem_req, mem_we, mem_addr, mem_be,
               mem_wdata, busy
    );
endinterface

// File: rtl/m68k_bus_target.sv
// Bus responder for the fx68k core: converts AS/UDS/LDS/RW bus cycles into a
// single outstanding req/ack memory transaction, answers with DTACKn, or with
// BERRn when memory does not answer within TIMEOUT_CYCLES.
// Ports: clk, rst (async, active high), bus (m68k_bus_target_if.slave:
// CPU strobes/address/data, dtack_n/berr_n/cpu_din, mem_* request, busy).
// Every output is a register; no input reaches dtack_n/berr_n combinationally.
module m68k_bus_target
    import m68k_bus_target_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = DEF_ADDR_BITS,
    parameter int unsigned TIMEOUT_BITS   = DEF_TIMEOUT_BITS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    m68k_bus_target_if.slave       bus
);

    localparam logic [TIMEOUT_BITS-1:0] CNT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    state_t                  state_q,     state_d;
    logic [TIMEOUT_BITS-1:0] cnt_q,       cnt_d;
    logic                    dtack_n_q,   dtack_n_d;
    logic                    berr_n_q,    berr_n_d;
    logic                    mem_req_q,   mem_req_d;
    logic                    mem_we_q,    mem_we_d;
    logic [ADDR_BITS-1:0]    mem_addr_q,  mem_addr_d;
    logic [BE_BITS-1:0]      mem_be_q,    mem_be_d;
    logic [DATA_BITS-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_BITS-1:0]    cpu_din_q,   cpu_din_d;
    logic                    busy_q,      busy_d;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dtack_n_d   = dtack_n_q;
        berr_n_d    = berr_n_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        cpu_din_d   = cpu_din_q;

        case (state_q)
            S_IDLE: begin
                if (bus_start(bus.as_n, bus.uds_n, bus.lds_n)) begin
                    mem_addr_d  = bus.addr;
                    mem_we_d    = ~bus.rw;
                    mem_be_d    = {~bus.uds_n, ~bus.lds_n};
                    mem_wdata_d = bus.cpu_dout;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + TIMEOUT_BITS'(1);
                end
                // Priority: ack beats timeout, timeout beats CPU abort.
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    dtack_n_d = 1'b0;
                    cnt_d     = '0;
                    if (!mem_we_q) begin
                        cpu_din_d = bus.mem_rdata;
                    end
                    state_d   = S_ACK;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    berr_n_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_BERR;
                end else if (bus.as_n) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end
            end
            S_ACK: begin
                if (bus.as_n) begin
                    dtack_n_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_BERR: begin
                if (bus.as_n) begin
                    berr_n_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dtack_n_q   <= 1'b1;
            berr_n_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            cpu_din_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dtack_n_q   <= dtack_n_d;
            berr_n_q    <= berr_n_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_din_q   <= cpu_din_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.dtack_n   = dtack_n_q;
    assign bus.berr_n    = berr_n_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_din   = cpu_din_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Self-checking bench for m68k_bus_target: transaction-level expectations
// derived from elapsed cycle counts, checked every falling edge.
module tb_m68k_bus_target;

    localparam int TO = 200;

    logic clk;
    logic rst;

    m68k_bus_target_if #(.ADDR_BITS(23)) bif ();

    m68k_bus_target #(
        .ADDR_BITS      (23),
        .TIMEOUT_BITS   (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs (value after the most recent rising edge).
    logic [15:0] e_din;
    logic        e_dtack, e_berr, e_req, e_we, e_busy;
    logic [22:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_exp_reset();
        e_din = 16'h0; e_dtack = 1'b1; e_berr = 1'b1; e_req = 1'b0; e_we = 1'b0;
        e_addr = 23'h0; e_be = 2'b00; e_wdata = 16'h0; e_busy = 1'b0;
    endtask

    // Per-cycle comparison against the expectations.
    always @(negedge clk) begin
        chk("cpu_din",   32'(bif.cpu_din),   32'(e_din));
        chk("dtack_n",   32'(bif.dtack_n),   32'(e_dtack));
        chk("berr_n",    32'(bif.berr_n),    32'(e_berr));
        chk("mem_req",   32'(bif.mem_req),   32'(e_req));
        chk("mem_we",    32'(bif.mem_we),    32'(e_we));
        chk("mem_addr",  32'(bif.mem_addr),  32'(e_addr));
        chk("mem_be",    32'(bif.mem_be),    32'(e_be));
        chk("mem_wdata", 32'(bif.mem_wdata), 32'(e_wdata));
        chk("busy",      32'(bif.busy),      32'(e_busy));
        chk("dtack_berr_excl", 32'(bif.dtack_n | bif.berr_n), 32'(1));
    end

    int  n_req_rise = 0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (bif.mem_req && !req_prev) n_req_rise++;
        req_prev = bif.mem_req;
    end

    // One CPU bus cycle plus the memory's reply. ack_at / abort_at are the
    // number of full request cycles before the event (-1 = never).
    // res: 0 = acked, 1 = bus error, 2 = aborted.
    task automatic run_txn(
        input  bit rd, input logic [22:0] a, input logic [15:0] wd,
        input  logic u_n, input logic l_n, input int ds_lag,
        input  int ack_at, input int abort_at, input logic [15:0] rdat,
        input  int hold, input bit late_ack, input bit rst_in_ack,
        output int res, output int req_edges, output int lat,
        output logic [15:0] c_din, output logic c_dtack, output logic c_berr,
        output logic c_req, output logic c_busy, output logic [1:0] c_be,
        output logic [22:0] c_addr, output logic [15:0] c_wdata, output logic c_we);
        int k;
        bit as_up;
        @(negedge clk);
        bif.as_n = 1'b0; bif.rw = rd; bif.addr = a; bif.cpu_dout = wd;
        bif.uds_n = 1'b1; bif.lds_n = 1'b1;
        repeat (ds_lag) @(negedge clk);
        bif.uds_n = u_n; bif.lds_n = l_n;
        @(posedge clk);
        e_req = 1'b1; e_we = !rd; e_addr = a; e_be = {~u_n, ~l_n};
        e_wdata = wd; e_busy = 1'b1;
        res = -1; k = 0; as_up = 1'b0;
        while (res < 0) begin
            @(negedge clk);
            bif.mem_ack   = (k == ack_at);
            bif.mem_rdata = (k == ack_at) ? rdat : 16'($urandom);
            if (k == abort_at) begin
                bif.as_n = 1'b1; bif.uds_n = 1'b1; bif.lds_n = 1'b1; as_up = 1'b1;
            end
            @(posedge clk);
            if (k == ack_at) begin
                e_req = 1'b0; e_dtack = 1'b0; res = 0;
                if (rd) e_din = rdat;
            end else if (k == TO - 1) begin
                e_req = 1'b0; e_berr = 1'b0; res = 1;
            end else if (k == abort_at) begin
                e_req = 1'b0; e_busy = 1'b0; res = 2;
            end else begin
                k++;
            end
        end
        req_edges = k + 1;
        lat       = k + 2;
        #1;
        c_din = bif.cpu_din; c_dtack = bif.dtack_n; c_berr = bif.berr_n;
        c_req = bif.mem_req; c_busy = bif.busy; c_be = bif.mem_be;
        c_addr = bif.mem_addr; c_wdata = bif.mem_wdata; c_we = bif.mem_we;
        @(negedge clk);
        bif.mem_ack = 1'b0;
        if (res == 2) return;
        if (rst_in_ack) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("rst_ack_dtack", 32'(bif.dtack_n), 32'(1));
            chk("rst_ack_din",   32'(bif.cpu_din), 32'(0));
            chk("rst_ack_req",   32'(bif.mem_req), 32'(0));
            chk("rst_ack_busy",  32'(bif.busy),    32'(0));
            chk("rst_ack_be",    32'(bif.mem_be),  32'(0));
            chk("rst_ack_addr",  32'(bif.mem_addr), 32'(0));
            set_exp_reset();
            bif.as_n = 1'b1; bif.uds_n = 1'b1; bif.lds_n = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        if (!as_up) begin
            repeat (hold) @(negedge clk);
            if (late_ack && res == 1) begin
                bif.mem_ack = 1'b1; bif.mem_rdata = 16'($urandom);
                @(negedge clk);
                bif.mem_ack = 1'b0;
            end
            bif.as_n = 1'b1; bif.uds_n = 1'b1; bif.lds_n = 1'b1;
        end
        @(posedge clk);
        e_dtack = 1'b1; e_berr = 1'b1; e_busy = 1'b0;
    endtask

    int          res, req_edges, lat, rq0;
    logic [15:0] c_din, c_wdata;
    logic        c_dtack, c_berr, c_req, c_busy, c_we;
    logic [1:0]  c_be;
    logic [22:0] c_addr;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        set_exp_reset();
        rst = 1'b1;
        bif.as_n = 1'b1; bif.uds_n = 1'b1; bif.lds_n = 1'b1; bif.rw = 1'b1;
        bif.addr = '0; bif.cpu_dout = '0; bif.mem_ack = 1'b0; bif.mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_dtack", 32'(bif.dtack_n), 32'(1));
        chk("reset_berr",  32'(bif.berr_n),  32'(1));
        chk("reset_din",   32'(bif.cpu_din), 32'(0));
        rst = 1'b0;

        // Read, ack after 3 request cycles.
        rq0 = n_req_rise;
        run_txn(1'b1, 23'h012345, 16'h0, 1'b0, 1'b0, 0, 3, -1, 16'hBEEF, 2, 1'b0, 1'b0,
                res, req_edges, lat, c_din, c_dtack, c_berr, c_req, c_busy, c_be, c_addr, c_wdata, c_we);
        chk("rd_din",    32'(c_din),   32'(16'hBEEF));
        chk("rd_dtack",  32'(c_dtack), 32'(0));
        chk("rd_we",     32'(c_we),    32'(0));
        chk("rd_pulses", 32'(n_req_rise - rq0), 32'(1));
        chk("rd_din_after", 32'(bif.cpu_din), 32'(16'hBEEF));

        // Lower-byte write, same-cycle ack, DS trailing AS.
        run_txn(1'b0, 23'h004000, 16'h12A5, 1'b1, 1'b0, 1, 0, -1, 16'h0, 1, 1'b0, 1'b0,
                res, req_edges, lat, c_din, c_dtack, c_berr, c_req, c_busy, c_be, c_addr, c_wdata, c_we);
        chk("wr_be",      32'(c_be),    32'(2'b01));
        chk("wr_addr",    32'(c_addr),  32'(23'h004000));
        chk("wr_wdata",   32'(c_wdata), 32'(16'h12A5));
        chk("wr_latency", 32'(lat),     32'(2));
        chk("wr_dtack",   32'(c_dtack), 32'(0));

        // Timeout with a late ack afterwards.
        run_txn(1'b1, 23'h7FFFFF, 16'h0, 1'b0, 1'b0, 0, -1, -1, 16'h0, 9, 1'b1, 1'b0,
                res, req_edges, lat, c_din, c_dtack, c_berr, c_req, c_busy, c_be, c_addr, c_wdata, c_we);
        chk("to_berr",  32'(c_berr),    32'(0));
        chk("to_req",   32'(c_req),     32'(0));
        chk("to_dtack", 32'(c_dtack),   32'(1));
        chk("to_cycle", 32'(req_edges), 32'(200));
        chk("to_din_kept", 32'(bif.cpu_din), 32'(16'hBEEF));

        // Abort during REQ.
        run_txn(1'b1, 23'h000100, 16'h0, 1'b0, 1'b0, 0, -1, 2, 16'h0, 0, 1'b0, 1'b0,
                res, req_edges, lat, c_din, c_dtack, c_berr, c_req, c_busy, c_be, c_addr, c_wdata, c_we);
        chk("ab_req",   32'(c_req),   32'(0));
        chk("ab_dtack", 32'(c_dtack), 32'(1));
        chk("ab_berr",  32'(c_berr),  32'(1));
        chk("ab_busy",  32'(c_busy),  32'(0));

        // Ack coincident with the last counter value.
        run_txn(1'b1, 23'h000200, 16'h0, 1'b0, 1'b0, 0, 199, -1, 16'h1234, 1, 1'b0, 1'b0,
                res, req_edges, lat, c_din, c_dtack, c_berr, c_req, c_busy, c_be, c_addr, c_wdata, c_we);
        chk("edge_dtack", 32'(c_dtack), 32'(0));
        chk("edge_berr",  32'(c_berr),  32'(1));
        chk("edge_din",   32'(c_din),   32'(16'h1234));

        // Reset while dtack is held, then a normal read.
        run_txn(1'b1, 23'h000300, 16'h0, 1'b0, 1'b0, 0, 1, -1, 16'h7777, 0, 1'b0, 1'b1,
                res, req_edges, lat, c_din, c_dtack, c_berr, c_req, c_busy, c_be, c_addr, c_wdata, c_we);
        run_txn(1'b1, 23'h000400, 16'h0, 1'b1, 1'b0, 0, 2, -1, 16'h5A5A, 1, 1'b0, 1'b0,
                res, req_edges, lat, c_din, c_dtack, c_berr, c_req, c_busy, c_be, c_addr, c_wdata, c_we);
        chk("post_rst_din",   32'(c_din),   32'(16'h5A5A));
        chk("post_rst_dtack", 32'(c_dtack), 32'(0));

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            bit          rd;
            int          r, ack_at, abort_at;
            logic [1:0]  strb;
            rd   = 1'($urandom);
            strb = 2'($urandom_range(1, 3));
            r    = $urandom_range(0, 99);
            ack_at   = (r < 3) ? -1 : $urandom_range(0, 5);
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            run_txn(rd, 23'($urandom), 16'($urandom), ~strb[1], ~strb[0],
                    rd ? 0 : $urandom_range(0, 2), ack_at, abort_at, 16'($urandom),
                    $urandom_range(0, 3), 1'($urandom), 1'b0,
                    res, req_edges, lat, c_din, c_dtack, c_berr, c_req, c_busy, c_be, c_addr, c_wdata, c_we);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
